// File: rtl/r5p_htif_console.sv
// HTIF tohost console: decodes the 64-bit tohost mailbox, executes putchar/exit commands,
// and buffers console bytes in a first-word-fall-through FIFO. Optional simulator echo: R5P_HTIF_CONSOLE_DISPLAY_EN.
module r5p_htif_console #(
    parameter logic [31:0] TOHOST   = 32'h8000_1000,
    parameter int          FIFO_DEP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tcb_vld,
    output logic        tcb_rdy,
    input  logic        tcb_wen,
    input  logic [31:0] tcb_adr,
    input  logic [31:0] tcb_wdt,
    output logic [31:0] tcb_rdt,
    output logic        chr_vld,
    input  logic        chr_rdy,
    output logic [7:0]  chr_dat,
    output logic        halt,
    output logic [30:0] exit_code,
    output logic        unk
);

    localparam int          AW        = (FIFO_DEP > 1) ? $clog2(FIFO_DEP) : 1;
    localparam logic [AW:0] FIFO_FULL = (AW+1)'(FIFO_DEP);
    localparam logic [31:0] ADR_LO    = TOHOST;
    localparam logic [31:0] ADR_HI    = TOHOST + 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_EXEC,
        ST_HALTED
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] lo_reg, lo_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] rdt_reg, rdt_next;
    logic        halt_reg, halt_next;
    logic [30:0] exit_reg, exit_next;
    logic        unk_reg, unk_next;

    logic [7:0]    fifo_mem [FIFO_DEP];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   cnt_reg;

    logic hit_lo, hit_hi, putchar_wr, fifo_full;
    logic trn, wr_active, lo_wr, hi_wr;
    logic is_halt, is_putc, is_zero, is_unk;
    logic push, pop;

    // ------------------------------------------------------------------
    // Bus decode and back-pressure
    // ------------------------------------------------------------------
    assign hit_lo     = (tcb_adr == ADR_LO);
    assign hit_hi     = (tcb_adr == ADR_HI);
    assign putchar_wr = (tcb_wdt[31:24] == 8'd1) && (tcb_wdt[23:16] == 8'd1);
    assign fifo_full  = (cnt_reg == FIFO_FULL);

    // A putchar commit is only stalled while the FIFO cannot take its byte;
    // once halted nothing executes, so nothing ever needs to stall.
    always_comb begin
        tcb_rdy = 1'b1;
        if (rst || state_reg == ST_EXEC) begin
            tcb_rdy = 1'b0;
        end else if (tcb_vld && tcb_wen && hit_hi && putchar_wr && fifo_full
                     && state_reg != ST_HALTED) begin
            tcb_rdy = 1'b0;
        end
    end

    assign trn       = tcb_vld & tcb_rdy;
    assign wr_active = trn & tcb_wen & (state_reg != ST_HALTED);
    assign lo_wr     = wr_active & hit_lo;
    assign hi_wr     = wr_active & hit_hi;

    // ------------------------------------------------------------------
    // Command decode; in EXEC the committed command is {hi_reg, lo_reg}
    // ------------------------------------------------------------------
    assign is_halt = (hi_reg[31:24] == 8'd0) && lo_reg[0];
    assign is_putc = (hi_reg[31:24] == 8'd1) && (hi_reg[23:16] == 8'd1);
    assign is_zero = ({hi_reg, lo_reg} == 64'd0);
    assign is_unk  = !is_halt && !is_putc && !is_zero;

    assign push = (state_reg == ST_EXEC) && is_putc;
    assign pop  = chr_vld && chr_rdy;

    always_comb begin
        state_next = state_reg;
        lo_next    = lo_reg;
        hi_next    = hi_reg;
        halt_next  = halt_reg;
        exit_next  = exit_reg;
        unk_next   = unk_reg;
        rdt_next   = rdt_reg;

        case (state_reg)
            ST_IDLE, ST_ARMED: begin
                if (hi_wr) begin
                    hi_next    = tcb_wdt;
                    state_next = ST_EXEC;
                end else if (lo_wr) begin
                    lo_next    = tcb_wdt;
                    state_next = ST_ARMED;
                end
            end
            ST_EXEC: begin
                // Clearing the mailbox is the acknowledge the host polls for.
                lo_next = 32'd0;
                hi_next = 32'd0;
                if (is_halt) begin
                    halt_next  = 1'b1;
                    exit_next  = lo_reg[31:1];
                    state_next = ST_HALTED;
                end else begin
                    state_next = ST_IDLE;
                end
                if (is_unk) begin
                    unk_next = 1'b1;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (trn && !tcb_wen) begin
            if (hit_lo) begin
                rdt_next = lo_reg;
            end else if (hit_hi) begin
                rdt_next = hi_reg;
            end else begin
                rdt_next = 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            lo_reg    <= 32'd0;
            hi_reg    <= 32'd0;
            rdt_reg   <= 32'd0;
            halt_reg  <= 1'b0;
            exit_reg  <= 31'd0;
            unk_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            lo_reg    <= lo_next;
            hi_reg    <= hi_next;
            rdt_reg   <= rdt_next;
            halt_reg  <= halt_next;
            exit_reg  <= exit_next;
            unk_reg   <= unk_next;
        end
    end

    // ------------------------------------------------------------------
    // Character FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= lo_reg[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_reg <= cnt_reg + (AW+1)'(1);
                2'b01:   cnt_reg <= cnt_reg - (AW+1)'(1);
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    assign chr_vld   = (cnt_reg != '0);
    assign chr_dat   = chr_vld ? fifo_mem[rd_ptr_reg] : 8'd0;
    assign tcb_rdt   = rdt_reg;
    assign halt      = halt_reg;
    assign exit_code = exit_reg;
    assign unk       = unk_reg;

`ifdef R5P_HTIF_CONSOLE_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (!rst && pop) begin
            $write("%c", chr_dat);
        end
        if (!rst && halt_next && !halt_reg) begin
            $display("HTIF: EXIT %0d", exit_next);
        end
    end
`else
`endif

endmodule

// File: tb/tb_r5p_htif_console.sv
// Randomized self-checking bench for r5p_htif_console against a queue-based mailbox/console model.
module tb_r5p_htif_console;

    localparam logic [31:0] TOHOST    = 32'h8000_1000;
    localparam int          DEP       = 8;
    localparam logic [31:0] ADR_LO    = TOHOST;
    localparam logic [31:0] ADR_HI    = TOHOST + 32'd4;
    localparam logic [31:0] ADR_OTHER = TOHOST + 32'd8;
    localparam logic [31:0] PUTC_HI   = 32'h0101_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tcb_vld = 1'b0;
    logic        tcb_rdy;
    logic        tcb_wen = 1'b0;
    logic [31:0] tcb_adr = 32'd0;
    logic [31:0] tcb_wdt = 32'd0;
    logic [31:0] tcb_rdt;
    logic        chr_vld;
    logic        chr_rdy = 1'b0;
    logic [7:0]  chr_dat;
    logic        halt;
    logic [30:0] exit_code;
    logic        unk;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    bit rand_rdy = 1'b0;

    logic [7:0] got_q[$];
    int         got_cyc_q[$];
    logic [7:0] exp_q[$];

    r5p_htif_console #(
        .TOHOST   (TOHOST),
        .FIFO_DEP (DEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tcb_vld   (tcb_vld),
        .tcb_rdy   (tcb_rdy),
        .tcb_wen   (tcb_wen),
        .tcb_adr   (tcb_adr),
        .tcb_wdt   (tcb_wdt),
        .tcb_rdt   (tcb_rdt),
        .chr_vld   (chr_vld),
        .chr_rdy   (chr_rdy),
        .chr_dat   (chr_dat),
        .halt      (halt),
        .exit_code (exit_code),
        .unk       (unk)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            chr_rdy = 1'($urandom_range(0, 1));
        end
    end

    // Console sink: records every byte handed over, with the cycle it left.
    always @(negedge clk) begin
        if (!rst && chr_vld && chr_rdy) begin
            got_q.push_back(chr_dat);
            got_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents one access and waits (bounded) for it to be accepted; returns #1 after the accepting edge.
    task automatic bus_xfer(input logic wen, input logic [31:0] adr, input logic [31:0] wdt,
                            output int trn_cyc);
        bit done;
        done    = 1'b0;
        trn_cyc = -1;
        tcb_vld = 1'b1;
        tcb_wen = wen;
        tcb_adr = adr;
        tcb_wdt = wdt;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (tcb_rdy === 1'b1) begin
                trn_cyc = cyc;
                done    = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        tcb_vld = 1'b0;
        n_checks++;
        if (!done) begin
            n_fails++;
            $display("FAIL bus_timeout adr=%h: got no tcb_rdy, required accept within 100 cycles", adr);
        end else begin
            $display("bus %s adr=%h wdt=%h cyc=%0d", wen ? "WR" : "RD", adr, wdt, trn_cyc);
        end
    endtask

    task automatic bus_read(input logic [31:0] adr, output logic [31:0] data);
        int c;
        bus_xfer(1'b0, adr, 32'd0, c);
        data = tcb_rdt;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        tcb_vld  = 1'b0;
        rand_rdy = 1'b0;
        chr_rdy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        tcb_vld = 1'b1;
        tcb_wen = 1'b1;
        tcb_adr = ADR_HI;
        tcb_wdt = PUTC_HI;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (tcb_rdy !== 1'b0)   begin n_fails++; $display("FAIL reset_rdy got %b exp 0", tcb_rdy); end
        n_checks++; if (chr_vld !== 1'b0)   begin n_fails++; $display("FAIL reset_chr_vld got %b exp 0", chr_vld); end
        n_checks++; if (chr_dat !== 8'd0)   begin n_fails++; $display("FAIL reset_chr_dat got %h exp 00", chr_dat); end
        n_checks++; if (halt !== 1'b0)      begin n_fails++; $display("FAIL reset_halt got %b exp 0", halt); end
        n_checks++; if (exit_code !== 31'd0) begin n_fails++; $display("FAIL reset_exit got %0d exp 0", exit_code); end
        n_checks++; if (unk !== 1'b0)       begin n_fails++; $display("FAIL reset_unk got %b exp 0", unk); end
        n_checks++; if (tcb_rdt !== 32'd0)  begin n_fails++; $display("FAIL reset_rdt got %h exp 0", tcb_rdt); end
        tcb_vld = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (tcb_rdy !== 1'b1)   begin n_fails++; $display("FAIL idle_rdy got %b exp 1", tcb_rdy); end
    endtask

    task automatic test_putchar();
        int          c, hc, first_cyc;
        logic [7:0]  first;
        logic [31:0] rd;
        do_reset();
        chr_rdy = 1'b1;
        bus_xfer(1'b1, ADR_LO, 32'h0000_0041, c);
        bus_xfer(1'b1, ADR_HI, PUTC_HI, hc);
        repeat (5) @(posedge clk);
        #1;
        first     = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        first_cyc = (got_cyc_q.size() > 0) ? got_cyc_q[0] : -1;
        n_checks++; if (got_q.size() != 1) begin n_fails++; $display("FAIL putc_count got %0d exp 1", got_q.size()); end
        n_checks++; if (first !== 8'h41)   begin n_fails++; $display("FAIL putc_data got %h exp 41", first); end
        n_checks++; if (first_cyc != hc + 2) begin n_fails++; $display("FAIL putc_latency got %0d exp %0d", first_cyc - hc, 2); end
        bus_read(ADR_LO, rd);
        n_checks++; if (rd !== 32'd0) begin n_fails++; $display("FAIL putc_lo_ack got %h exp 0", rd); end
        bus_read(ADR_HI, rd);
        n_checks++; if (rd !== 32'd0) begin n_fails++; $display("FAIL putc_hi_ack got %h exp 0", rd); end
        n_checks++; if (halt !== 1'b0 || unk !== 1'b0) begin n_fails++; $display("FAIL putc_flags got halt=%b unk=%b exp 0 0", halt, unk); end
    endtask

    task automatic test_halt();
        int          c;
        logic [31:0] rd;
        do_reset();
        bus_xfer(1'b1, ADR_LO, 32'h0000_0001, c);
        bus_xfer(1'b1, ADR_HI, 32'd0, c);
        n_checks++; if (halt !== 1'b0)    begin n_fails++; $display("FAIL halt_early got %b exp 0", halt); end
        n_checks++; if (tcb_rdy !== 1'b0) begin n_fails++; $display("FAIL exec_rdy got %b exp 0", tcb_rdy); end
        @(posedge clk);
        #1;
        n_checks++; if (halt !== 1'b1)       begin n_fails++; $display("FAIL halt_set got %b exp 1", halt); end
        n_checks++; if (exit_code !== 31'd0) begin n_fails++; $display("FAIL halt_exit0 got %0d exp 0", exit_code); end
        bus_xfer(1'b1, ADR_LO, 32'h0000_0007, c);
        bus_xfer(1'b1, ADR_HI, 32'd0, c);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (halt !== 1'b1 || exit_code !== 31'd0) begin n_fails++; $display("FAIL halt_sticky got halt=%b exit=%0d exp 1 0", halt, exit_code); end
        bus_read(ADR_LO, rd);
        n_checks++; if (rd !== 32'd0) begin n_fails++; $display("FAIL halted_lo got %h exp 0", rd); end

        do_reset();
        bus_xfer(1'b1, ADR_LO, 32'h0000_0007, c);
        bus_xfer(1'b1, ADR_HI, 32'd0, c);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (halt !== 1'b1 || exit_code !== 31'd3) begin n_fails++; $display("FAIL halt_exit3 got halt=%b exit=%0d exp 1 3", halt, exit_code); end
    endtask

    task automatic test_unknown();
        int          c;
        logic [31:0] rd, v;
        do_reset();
        chr_rdy = 1'b1;
        v = $urandom;
        bus_xfer(1'b1, ADR_LO, v, c);
        bus_read(ADR_LO, rd);
        n_checks++; if (rd !== v)     begin n_fails++; $display("FAIL armed_lo got %h exp %h", rd, v); end
        bus_read(ADR_HI, rd);
        n_checks++; if (rd !== 32'd0) begin n_fails++; $display("FAIL armed_hi got %h exp 0", rd); end
        bus_xfer(1'b1, ADR_LO, 32'd0, c);
        bus_xfer(1'b1, ADR_HI, 32'h0203_0000, c);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (unk !== 1'b1)    begin n_fails++; $display("FAIL unk_set got %b exp 1", unk); end
        n_checks++; if (halt !== 1'b0)   begin n_fails++; $display("FAIL unk_halt got %b exp 0", halt); end
        n_checks++; if (got_q.size() != 0 || chr_vld !== 1'b0) begin n_fails++; $display("FAIL unk_push got %0d bytes exp 0", got_q.size()); end
        bus_xfer(1'b1, ADR_OTHER, $urandom, c);
        bus_read(ADR_OTHER, rd);
        n_checks++; if (rd !== 32'd0) begin n_fails++; $display("FAIL other_read got %h exp 0", rd); end

        do_reset();
        bus_xfer(1'b1, ADR_HI, 32'd0, c);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (unk !== 1'b0 || halt !== 1'b0) begin n_fails++; $display("FAIL zero_cmd got unk=%b halt=%b exp 0 0", unk, halt); end
    endtask

    task automatic test_fifo_full();
        int c;
        do_reset();
        for (int i = 0; i <= DEP; i++) exp_q.push_back(8'h61 + 8'(i));
        for (int i = 0; i < DEP; i++) begin
            bus_xfer(1'b1, ADR_LO, {24'd0, exp_q[i]}, c);
            bus_xfer(1'b1, ADR_HI, PUTC_HI, c);
        end
        bus_xfer(1'b1, ADR_LO, {24'd0, exp_q[DEP]}, c);
        tcb_vld = 1'b1;
        tcb_wen = 1'b1;
        tcb_adr = ADR_HI;
        tcb_wdt = PUTC_HI;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (tcb_rdy !== 1'b0) begin n_fails++; $display("FAIL full_stall[%0d] got rdy=%b exp 0", i, tcb_rdy); end
        end
        n_checks++; if (chr_vld !== 1'b1 || chr_dat !== 8'h61) begin n_fails++; $display("FAIL full_head got vld=%b dat=%h exp 1 61", chr_vld, chr_dat); end
        @(posedge clk);
        #1;
        chr_rdy = 1'b1;
        @(posedge clk);
        #1;
        chr_rdy = 1'b0;
        @(negedge clk);
        n_checks++; if (tcb_rdy !== 1'b1) begin n_fails++; $display("FAIL full_release got rdy=%b exp 1", tcb_rdy); end
        @(posedge clk);
        #1;
        tcb_vld = 1'b0;
        $display("bus WR adr=%h wdt=%h cyc=%0d", ADR_HI, PUTC_HI, cyc - 1);
        chr_rdy = 1'b1;
        repeat (DEP + 6) @(posedge clk);
        #1;
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fails++; $display("FAIL full_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fails++; $display("FAIL full_order[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int          c;
        logic [31:0] rd;
        do_reset();
        bus_xfer(1'b1, ADR_LO, 32'h0000_0001, c);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (tcb_rdy !== 1'b0) begin n_fails++; $display("FAIL midrst_rdy got %b exp 0", tcb_rdy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_xfer(1'b1, ADR_HI, 32'd0, c);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (halt !== 1'b0 || exit_code !== 31'd0) begin n_fails++; $display("FAIL midrst_halt got halt=%b exit=%0d exp 0 0", halt, exit_code); end
        n_checks++; if (unk !== 1'b0 || chr_vld !== 1'b0 || chr_dat !== 8'd0) begin n_fails++; $display("FAIL midrst_outs got unk=%b vld=%b dat=%h exp 0 0 00", unk, chr_vld, chr_dat); end
        bus_read(ADR_LO, rd);
        n_checks++; if (rd !== 32'd0) begin n_fails++; $display("FAIL midrst_lo got %h exp 0", rd); end
    endtask

    // Random putchars, mailbox reads and stray reads against a model of the mailbox and console stream.
    task automatic test_random();
        int          c, op;
        logic [31:0] lo_m, v, rd, adr;
        logic [7:0]  ch;
        do_reset();
        rand_rdy = 1'b1;
        lo_m     = 32'd0;
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 9);
            if (op < 6) begin
                ch = 8'($urandom);
                bus_xfer(1'b1, ADR_LO, {24'($urandom), ch}, c);
                bus_xfer(1'b1, ADR_HI, {16'h0101, 16'($urandom)}, c);
                exp_q.push_back(ch);
                lo_m = 32'd0;
            end else if (op < 8) begin
                v = $urandom;
                bus_xfer(1'b1, ADR_LO, v, c);
                lo_m = v;
                bus_read(ADR_LO, rd);
                n_checks++; if (rd !== lo_m) begin n_fails++; $display("FAIL rnd_lo got %h exp %h", rd, lo_m); end
            end else begin
                case ($urandom_range(0, 3))
                    0:       adr = ADR_HI;
                    1:       adr = ADR_OTHER;
                    2:       adr = TOHOST - 32'd4;
                    default: adr = TOHOST + 32'd1;
                endcase
                bus_read(adr, rd);
                n_checks++; if (rd !== 32'd0) begin n_fails++; $display("FAIL rnd_read adr=%h got %h exp 0", adr, rd); end
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        chr_rdy = 1'b1;
        repeat (DEP + 6) @(posedge clk);
        #1;
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fails++; $display("FAIL rnd_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fails++; $display("FAIL rnd_order[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (halt !== 1'b0 || unk !== 1'b0) begin n_fails++; $display("FAIL rnd_flags got halt=%b unk=%b exp 0 0", halt, unk); end
    endtask

    initial begin
        test_reset();
        test_putchar();
        test_halt();
        test_unknown();
        test_fifo_full();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/r5p_htif_console.md
R5P_HTIF_CONSOLE -- requirements
Module: r5p_htif_console

Interface
REQ-001 Parameters SHALL be: TOHOST, default 32'h8000_1000, tohost word address (8-byte aligned); FIFO_DEP, default 16, character FIFO depth (power of 2, >=2).
REQ-002 Ports SHALL be, clock and reset first: clk in 1 system clock; rst in 1 reset; tcb_vld in 1 request valid; tcb_rdy out 1 request ready; tcb_wen in 1 write enable; tcb_adr in 32 byte address; tcb_wdt in 32 write data; tcb_rdt out 32 read data; chr_vld out 1 char valid; chr_rdy in 1 char ready; chr_dat out 8 char byte; halt out 1 HTIF halt; exit_code out 31 halt exit code; unk out 1 unknown command seen.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-004 Transfer trn SHALL be tcb_vld & tcb_rdy; only full 32-bit word accesses are decoded.

Function
REQ-005 The block SHALL decode two words: LO = TOHOST (tohost[31:0]) and HI = TOHOST+4 (tohost[63:32]); other addresses SHALL be ignored on write and read as 0.
REQ-006 A write trn to LO SHALL latch tcb_wdt into lo_reg; FSM goes IDLE->ARMED.
REQ-007 A write trn to HI SHALL commit command {tcb_wdt, lo_reg}: device = [63:56], cmd = [55:48], payload = [47:0]; FSM goes to EXEC for exactly one cycle, then IDLE.
REQ-008 HI write in IDLE SHALL commit with the current lo_reg (0 after clear).
REQ-009 Command with device 0 and payload[0]=1 SHALL set halt (sticky) and exit_code = payload[31:1], in the cycle after EXEC; FSM enters HALTED.
REQ-010 Command with device 1, cmd 1 SHALL push payload[7:0] into the FIFO in EXEC.
REQ-011 Any other non-zero command SHALL set unk (sticky); an all-zero command SHALL be a no-op.
REQ-012 Leaving EXEC SHALL clear lo_reg and hi_reg to 0 (host acknowledge); reads of LO/HI SHALL return lo_reg/hi_reg (hi_reg = last HI write until cleared).
REQ-013 tcb_rdt SHALL be registered: valid the cycle after a read trn, held until the next read trn.
REQ-014 tcb_rdy SHALL be 1 except: deasserted (combinationally) when a HI write is presented, a putchar decodes, and the FIFO is full; also 0 during EXEC.
REQ-015 In HALTED all writes SHALL be accepted and ignored; reads remain served.
REQ-016 FIFO SHALL be first-word-fall-through: chr_vld = not empty, chr_dat = head; pop on chr_vld & chr_rdy.
REQ-017 Simultaneous push and pop SHALL keep occupancy unchanged, including when full; pointers SHALL wrap modulo FIFO_DEP.
REQ-018 Latency: HI write trn to chr_vld rise on empty FIFO SHALL be 2 cycles.

Reset
REQ-019 While rst=1: FSM=IDLE, lo_reg=hi_reg=0, FIFO empty, tcb_rdy=0, tcb_rdt=0, chr_vld=0, chr_dat=0, halt=0, exit_code=0, unk=0.
REQ-020 rst mid-command (ARMED/EXEC) SHALL discard the command with no FIFO push and no halt.

Configuration
REQ-021 Macro R5P_HTIF_CONSOLE_DISPLAY_EN: when defined, every FIFO pop SHALL also $write the character to the simulator console and halt rise SHALL $display "HTIF: EXIT <exit_code>"; when undefined, no simulator output, identical port behaviour.

Verification
REQ-022 LO<=0x0000_0041, HI<=0x0101_0000, chr_rdy=1 -> chr_dat=0x41, chr_vld 2 cycles after HI trn, LO/HI read back 0.
REQ-023 LO<=0x0000_0001, HI<=0 -> halt=1, exit_code=0; later LO<=0x0000_0007, HI<=0 -> ignored, exit_code stays 0.
REQ-024 LO<=0x0000_0007, HI<=0 -> halt=1, exit_code=3.
REQ-025 chr_rdy=0, FIFO_DEP+1 putchars 'a'.. -> tcb_rdy=0 on last HI write until one pop, then accepted; output order preserved, no loss.
REQ-026 HI<=0x0203_0000 -> unk=1, no FIFO push, no halt; read of TOHOST+8 -> 0.
REQ-027 rst asserted one cycle after LO write -> HI<=0 afterwards yields no halt, all outputs at reset values.
